sr_fetch: RTL and testbench

- Instruction fetch stage for schoolRISCV; sits directly upstream of the instruction decoder and control unit.
- Issues word requests to a variable-latency instruction memory and buffers returned words with their PCs in a small prefetch FIFO.
- Presents {instr, instrPc} to decode through a valid/ready handshake.
- Consumes the taken-branch decision (pcSrc plus target) as a redirect that flushes the FIFO and restarts fetch.

---
 rtl/sr_fetch.sv | 139 +++++++++++++
 tb/tb_sr_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_fetch.sv
// schoolRISCV instruction fetch: one-outstanding memory requests, DEPTH-entry prefetch FIFO, branch redirect.
// Optional macro SR_FETCH_BYPASS_EN presents an acked word to decode in the same cycle when the FIFO is empty.
module sr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imReq,
  output logic [31:0] imAddr,
  input  logic        imAck,
  input  logic [31:0] imData,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPc
);

  // Handshakes: memory side holds imReq/imAddr until imAck (imAck without imReq is ignored);
  // decode side transfers the head word on any cycle where instrValid & instrReady.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wrPtr, rdPtr;
  logic [31:0]     fetchPc, targetPc;
  logic [31:0]     instrMem [DEPTH];
  logic [31:0]     pcMem    [DEPTH];
  logic [31:0]     redirAligned;
  logic            acked, headValid, bypass, push, pop, flush;

  assign redirAligned = redirectPc & ~32'h3;
  assign acked        = imReq & imAck;
  assign headValid    = (count != '0);
  assign flush        = redirect & (state != IDLE);
  assign pop          = headValid & instrReady;
  assign push         = (state == RUN) & acked & ~redirect & ~(bypass & instrReady);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; an ack that completes a drop always returns to RUN, taking any same-cycle redirect target
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = RUN;
      RUN:     if (redirect && imReq && !imAck) stateNext = DROP;
      DROP:    if (imAck) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imReq = 1'b0;
    case (state)
      RUN:     imReq = (count < CW'(DEPTH));
      DROP:    imReq = 1'b1;
      default: imReq = 1'b0;
    endcase
  end

  assign imAddr = fetchPc;

`ifdef SR_FETCH_BYPASS_EN
  assign bypass     = (state == RUN) & ~headValid & acked & ~redirect;
  assign instrValid = headValid | bypass;
  assign instr      = bypass ? imData  : instrMem[rdPtr];
  assign instrPc    = bypass ? fetchPc : pcMem[rdPtr];
`else
  assign bypass     = 1'b0;
  assign instrValid = headValid;
  assign instr      = instrMem[rdPtr];
  assign instrPc    = pcMem[rdPtr];
`endif

  // Fetch address tracking; targetPc parks the redirect while a stale request drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc  <= RESET_PC;
      targetPc <= RESET_PC;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            if (imReq && !imAck) targetPc <= redirAligned;
            else                 fetchPc  <= redirAligned;
          end else if (acked) begin
            fetchPc <= fetchPc + 32'd4;
          end
        end
        DROP: begin
          if (imAck)         fetchPc  <= redirect ? redirAligned : targetPc;
          else if (redirect) targetPc <= redirAligned;
        end
        default: ;
      endcase
    end
  end

  // FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage, cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem[i] <= '0;
        pcMem[i]    <= '0;
      end
    end else if (push) begin
      instrMem[wrPtr] <= imData;
      pcMem[wrPtr]    <= fetchPc;
    end
  end

endmodule

// File: tb/tb_sr_fetch.sv
// Directed testbench for sr_fetch: bench-side variable-latency memory, fixed-cycle expectations.
// Build with +define+SR_FETCH_BYPASS_EN to check the zero-latency variant.
module tb_sr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imReq, imAck, instrValid, instrReady, redirect;
  logic [31:0] imAddr, imData, instr, instrPc, redirectPc;

  int nCompared   = 0;
  int nMismatched = 0;

  logic        memEn;
  int          memLat;
  int          waitCnt;
  logic        ovrEn;
  logic [31:0] ovrData;

  always #5 clk = ~clk;

  sr_fetch #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imReq(imReq), .imAddr(imAddr), .imAck(imAck), .imData(imData),
    .instrValid(instrValid), .instr(instr), .instrPc(instrPc), .instrReady(instrReady),
    .redirect(redirect), .redirectPc(redirectPc)
  );

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (32'h1300_0000 | a);
  endfunction

  // Memory model: acks after memLat wait cycles of a held request
  assign imAck  = memEn && imReq && (waitCnt >= memLat);
  assign imData = ovrEn ? ovrData : dataOf(imAddr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          waitCnt <= 0;
    else if (memEn && imReq && !imAck)   waitCnt <= waitCnt + 1;
    else                                 waitCnt <= 0;
  end

  task automatic apply_reset();
    rst_n = 1'b0; memEn = 1'b0; memLat = 0; ovrEn = 1'b0; ovrData = 32'h0;
    instrReady = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memEn = 1'b0; memLat = 0; ovrEn = 1'b0; ovrData = 32'h0;
    instrReady = 1'b0; redirect = 1'b1; redirectPc = 32'h80;
    @(negedge clk);
    nCompared++; if (imReq !== 1'b0) begin nMismatched++; $display("FAIL reset_imReq: got %b expected 0", imReq); end
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL reset_valid: got %b expected 0", instrValid); end
    nCompared++; if (instr !== 32'h0) begin nMismatched++; $display("FAIL reset_instr: got %h expected 0", instr); end
    nCompared++; if (instrPc !== 32'h0) begin nMismatched++; $display("FAIL reset_pc: got %h expected 0", instrPc); end
    rst_n = 1'b1;
    @(negedge clk);
    nCompared++; if (imReq !== 1'b1) begin nMismatched++; $display("FAIL idle_run_imReq: got %b expected 1", imReq); end
    nCompared++; if (imAddr !== 32'h0) begin nMismatched++; $display("FAIL idle_redirect_ignored: got %h expected 0", imAddr); end
    redirect = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] expPc;
    apply_reset();
    memEn = 1'b1; instrReady = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      nCompared++; if (imAddr !== 32'(4 * i)) begin nMismatched++; $display("FAIL stream_addr%0d: got %h expected %h", i, imAddr, 32'(4 * i)); end
`ifdef SR_FETCH_BYPASS_EN
      expPc = 32'(4 * i);
`else
      expPc = 32'(4 * (i - 1));
`endif
      if (i > 0 || expPc == 32'h0) begin
        nCompared++; if (instrValid !== 1'b1) begin nMismatched++; $display("FAIL stream_valid%0d: got %b expected 1", i, instrValid); end
        nCompared++; if (instrPc !== expPc) begin nMismatched++; $display("FAIL stream_pc%0d: got %h expected %h", i, instrPc, expPc); end
        nCompared++; if (instr !== dataOf(expPc)) begin nMismatched++; $display("FAIL stream_instr%0d: got %h expected %h", i, instr, dataOf(expPc)); end
      end else begin
        nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL stream_latency: got %b expected 0", instrValid); end
      end
    end
  endtask

  task automatic test_full();
    apply_reset();
    memEn = 1'b1; instrReady = 1'b0; #1;
    nCompared++; if (imAddr !== 32'h0) begin nMismatched++; $display("FAIL full_addr0: got %h expected 0", imAddr); end
    tick(1);
    nCompared++; if (imAddr !== 32'h4) begin nMismatched++; $display("FAIL full_addr4: got %h expected 4", imAddr); end
    tick(1);
    nCompared++; if (imReq !== 1'b0) begin nMismatched++; $display("FAIL full_stop: got %b expected 0", imReq); end
    nCompared++; if (instrPc !== 32'h0) begin nMismatched++; $display("FAIL full_head: got %h expected 0", instrPc); end
    tick(1);
    nCompared++; if (imReq !== 1'b0) begin nMismatched++; $display("FAIL full_hold: got %b expected 0", imReq); end
    instrReady = 1'b1; #1;
    nCompared++; if (imReq !== 1'b0) begin nMismatched++; $display("FAIL full_no_bypass_req: got %b expected 0", imReq); end
    tick(1);
    nCompared++; if (imReq !== 1'b1) begin nMismatched++; $display("FAIL full_resume: got %b expected 1", imReq); end
    nCompared++; if (imAddr !== 32'h8) begin nMismatched++; $display("FAIL full_resume_addr: got %h expected 8", imAddr); end
    nCompared++; if (instrPc !== 32'h4) begin nMismatched++; $display("FAIL full_pop2: got %h expected 4", instrPc); end
    tick(1);
    nCompared++; if (instrPc !== 32'h8) begin nMismatched++; $display("FAIL full_after: got %h expected 8", instrPc); end
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    memEn = 1'b1; memLat = 2; instrReady = 1'b1;
    tick(6);
    nCompared++; if (imAddr !== 32'h8) begin nMismatched++; $display("FAIL rp_addr8: got %h expected 8", imAddr); end
    redirect = 1'b1; redirectPc = 32'h100;
    tick(1);
    redirect = 1'b0;
    nCompared++; if (imReq !== 1'b1 || imAddr !== 32'h8) begin nMismatched++; $display("FAIL rp_hold1: got %b/%h expected 1/8", imReq, imAddr); end
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL rp_flush: got %b expected 0", instrValid); end
    tick(1);
    nCompared++; if (imReq !== 1'b1 || imAddr !== 32'h8) begin nMismatched++; $display("FAIL rp_hold2: got %b/%h expected 1/8", imReq, imAddr); end
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL rp_drop_hidden: got %b expected 0", instrValid); end
    tick(1);
    nCompared++; if (imAddr !== 32'h100) begin nMismatched++; $display("FAIL rp_newaddr: got %h expected 100", imAddr); end
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL rp_empty: got %b expected 0", instrValid); end
    tick(2);
`ifdef SR_FETCH_BYPASS_EN
    nCompared++; if (instrValid !== 1'b1 || instrPc !== 32'h100) begin nMismatched++; $display("FAIL rp_first_pc: got %b/%h expected 1/100", instrValid, instrPc); end
    tick(1);
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL rp_consumed: got %b expected 0", instrValid); end
`else
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL rp_pre_first: got %b expected 0", instrValid); end
    tick(1);
    nCompared++; if (instrValid !== 1'b1 || instrPc !== 32'h100) begin nMismatched++; $display("FAIL rp_first_pc: got %b/%h expected 1/100", instrValid, instrPc); end
    nCompared++; if (instr !== dataOf(32'h100)) begin nMismatched++; $display("FAIL rp_first_instr: got %h expected %h", instr, dataOf(32'h100)); end
`endif
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    memEn = 1'b1; instrReady = 1'b0;
    tick(1);
    ovrEn = 1'b1; ovrData = 32'hDEAD_BEEF; redirect = 1'b1; redirectPc = 32'h40;
    tick(1);
    memEn = 1'b0; ovrEn = 1'b0; redirect = 1'b0; #1;
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL ra_flush: got %b expected 0", instrValid); end
    nCompared++; if (imReq !== 1'b1 || imAddr !== 32'h40) begin nMismatched++; $display("FAIL ra_addr: got %b/%h expected 1/40", imReq, imAddr); end
    tick(1);
    memEn = 1'b1; instrReady = 1'b1; #1;
`ifdef SR_FETCH_BYPASS_EN
    nCompared++; if (instrValid !== 1'b1 || instrPc !== 32'h40) begin nMismatched++; $display("FAIL ra_first: got %b/%h expected 1/40", instrValid, instrPc); end
    tick(1);
    nCompared++; if (instrPc !== 32'h44) begin nMismatched++; $display("FAIL ra_next: got %h expected 44", instrPc); end
`else
    nCompared++; if (instrValid !== 1'b0) begin nMismatched++; $display("FAIL ra_latency: got %b expected 0", instrValid); end
    tick(1);
    nCompared++; if (instrValid !== 1'b1 || instrPc !== 32'h40) begin nMismatched++; $display("FAIL ra_first: got %b/%h expected 1/40", instrValid, instrPc); end
    nCompared++; if (instr !== dataOf(32'h40)) begin nMismatched++; $display("FAIL ra_instr: got %h expected %h", instr, dataOf(32'h40)); end
`endif
  endtask

  task automatic test_double_redirect();
    apply_reset();
    memEn = 1'b1; memLat = 2; instrReady = 1'b1;
    redirect = 1'b1; redirectPc = 32'h200;
    tick(1);
    redirectPc = 32'h300;
    nCompared++; if (imReq !== 1'b1 || imAddr !== 32'h0) begin nMismatched++; $display("FAIL dr_hold1: got %b/%h expected 1/0", imReq, imAddr); end
    tick(1);
    redirect = 1'b0;
    nCompared++; if (imAddr !== 32'h0 || instrValid !== 1'b0) begin nMismatched++; $display("FAIL dr_hold2: got %h/%b expected 0/0", imAddr, instrValid); end
    tick(1);
    nCompared++; if (imAddr !== 32'h300) begin nMismatched++; $display("FAIL dr_target: got %h expected 300", imAddr); end
`ifdef SR_FETCH_BYPASS_EN
    tick(2);
`else
    tick(3);
`endif
    nCompared++; if (instrValid !== 1'b1 || instrPc !== 32'h300) begin nMismatched++; $display("FAIL dr_first: got %b/%h expected 1/300", instrValid, instrPc); end
  endtask

  task automatic test_wrap();
    apply_reset();
    memEn = 1'b1; instrReady = 1'b0;
    tick(2);
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFF;
    tick(1);
    redirect = 1'b0;
    nCompared++; if (imAddr !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL wrap_align: got %h expected fffffffc", imAddr); end
    tick(1);
    nCompared++; if (imAddr !== 32'h0) begin nMismatched++; $display("FAIL wrap_addr: got %h expected 0", imAddr); end
    nCompared++; if (instrValid !== 1'b1 || instrPc !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL wrap_head: got %b/%h expected 1/fffffffc", instrValid, instrPc); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    memEn = 1'b1; instrReady = 1'b0;
    tick(2);
    nCompared++; if (instrValid !== 1'b1) begin nMismatched++; $display("FAIL mid_pre: got %b expected 1", instrValid); end
    #2 rst_n = 1'b0;
    #1;
    nCompared++; if (imReq !== 1'b0 || instrValid !== 1'b0) begin nMismatched++; $display("FAIL mid_async: got %b/%b expected 0/0", imReq, instrValid); end
    nCompared++; if (instr !== 32'h0 || instrPc !== 32'h0) begin nMismatched++; $display("FAIL mid_clear: got %h/%h expected 0/0", instr, instrPc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_pending();
    test_redirect_ack();
    test_double_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
